// File: rtl/counter_sequencer_if.sv
// ============================================================================
// Module      : counter_sequencer_if
// Description : Command and status bundle between a run-control master and
//               the counter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface counter_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
);

  // Commands and configuration
  logic             start;
  logic             stop;
  logic             pause;
  logic             dir;
  logic             wrap;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] limit;

  // Status
  logic [WIDTH-1:0] count;
  logic             running;
  logic             paused;
  logic             tick;
  logic             done;

  // Controller side: issues commands, observes status
  modport master (
    output start, stop, pause, dir, wrap, div, limit,
    input  count, running, paused, tick, done
  );

  // Sequencer side: receives commands, produces status
  modport slave (
    input  start, stop, pause, dir, wrap, div, limit,
    output count, running, paused, tick, done
  );

endinterface

`default_nettype wire

// File: rtl/counter_sequencer.sv
// ============================================================================
// Module      : counter_sequencer
// Description : Sequenced up/down counter with prescaler, pause, one-shot or
//               wrap mode. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic                clk,
  input  logic                rst,
  counter_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] r_div;
  logic [WIDTH-1:0] r_limit;
  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_wrap;
  logic             r_running;
  logic             r_paused;
  logic             r_tick;
  logic             r_done;

  logic             w_step;
  logic [WIDTH-1:0] w_end;
  logic [WIDTH-1:0] w_reload;
  logic             w_at_end;
  logic             w_finish;

  // Step/terminal decode from the latched configuration
  assign w_step   = (r_presc == r_div);
  assign w_end    = r_dir ? '0 : r_limit;
  assign w_reload = r_dir ? r_limit : '0;
  assign w_at_end = (r_count == w_end);
  // A one-shot completing this cycle beats a simultaneous pause request
  assign w_finish = (r_state == ST_RUN) && w_step && w_at_end && !r_wrap;

  // Sequencer state, prescaler, count and registered status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_presc   <= '0;
      r_div     <= '0;
      r_limit   <= '0;
      r_count   <= '0;
      r_dir     <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_paused  <= 1'b0;
      r_tick    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (bus.stop) begin
        r_state   <= ST_IDLE;
        r_count   <= '0;
        r_presc   <= '0;
        r_running <= 1'b0;
        r_paused  <= 1'b0;
      end else if (bus.start) begin
        r_dir     <= bus.dir;
        r_wrap    <= bus.wrap;
        r_div     <= bus.div;
        r_limit   <= bus.limit;
        r_count   <= bus.dir ? bus.limit : '0;
        r_presc   <= '0;
        r_state   <= ST_RUN;
        r_running <= 1'b1;
        r_paused  <= 1'b0;
      end else begin
        case (r_state)
          ST_RUN: begin
            // The step due this cycle executes even if pause is also sampled
            if (w_step) begin
              r_presc <= '0;
              r_tick  <= 1'b1;
              if (!w_at_end) begin
                r_count <= r_dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
              end else if (r_wrap) begin
                r_count <= w_reload;
              end
            end else begin
              r_presc <= r_presc + DIV_W'(1);
            end

            if (w_finish) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_running <= 1'b0;
            end else if (bus.pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
              r_paused  <= 1'b1;
            end
          end

          ST_PAUSE: begin
            // Prescaler and count stay frozen; resume where we left off
            if (!bus.pause) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
              r_paused  <= 1'b0;
            end
          end

          default: begin
            // IDLE and DONE hold until start or stop
          end
        endcase
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.paused  = r_paused;
  assign bus.tick    = r_tick;
  assign bus.done    = r_done;

endmodule

`default_nettype wire

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Run-control front end for the 8-bit LED/display counter datapath.
- Replaces the free-running increment with a sequenced counter: start, stop, pause, count direction, terminal limit, one-shot or wrap mode.
- A programmable prescaler sets the step rate, so board clocks produce visible counting.
- Outputs feed the per-bit LED assigns directly.

Parameters:
- WIDTH, 8, counter width.
- DIV_W, 24, prescaler divisor width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level-sampled each clk; begins or restarts a sequence.
- stop  in  1  abort to IDLE.
- pause  in  1  level: holds RUN while high.
- dir  in  1  0 = count up (0 to limit), 1 = count down (limit to 0); latched at start.
- wrap  in  1  0 = one-shot, 1 = reload at terminal and continue; latched at start.
- div  in  DIV_W  step period minus 1, in clk cycles; latched at start.
- limit  in  WIDTH  terminal/initial value; latched at start.
- count  out  WIDTH  current count value, registered.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- tick  out  1  one-cycle pulse on every step event.
- done  out  1  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (async, rst=1): state IDLE; count, prescaler, running, paused, tick, done all 0; latched config cleared to 0.
- States: IDLE, RUN, PAUSE, DONE.
- Command priority each cycle: stop > start > pause.
- stop, any state: next cycle IDLE, count=0, prescaler=0, tick/done=0.
- start, any state without stop:
  - Latch dir/wrap/div/limit.
  - count = 0 if up, limit if down; prescaler = 0.
  - Next state RUN; restarts a sequence already in RUN/PAUSE/DONE.
- RUN:
  - Prescaler increments each clk.
  - When prescaler == div_l: prescaler reset to 0 and tick=1 for that cycle.
  - div_l=0 gives a tick every clk.
  - On tick with count != end (end = limit_l if up, 0 if down): count ±1.
  - On tick with count == end:
    - wrap_l=1: count reloads its start value (0 up / limit_l down), stay RUN.
    - wrap_l=0: count holds end, state DONE, done=1 for exactly that cycle.
  - limit_l=0: every tick is terminal (count stays 0).
- Step timing:
  - First tick occurs div_l+1 clks after entering RUN.
  - One-shot completion takes (limit_l+1)·(div_l+1) clks from RUN entry to the done pulse.
- PAUSE:
  - Entered from RUN when pause=1, effective next cycle.
  - Prescaler and count frozen, tick=0.
  - Returns to RUN when pause=0, resuming the prescaler value exactly.
  - A tick due in the same cycle pause is sampled high still executes.
- DONE: count held at end, running=0; exits only on start or stop. pause is ignored.
- IDLE: count=0, all flags 0; pause ignored.
- Arithmetic: count is modulo 2^WIDTH by construction and never passes limit_l. Prescaler width is DIV_W and never exceeds div_l.
- Input changes to div/limit/dir/wrap outside a start cycle have no effect.
- rst asserted mid-sequence returns all state and outputs to reset values immediately. No done pulse is generated.

Test Plan:
- Up one-shot: rst then start with limit=3, div=1, dir=0, wrap=0.
  - count 0,1,2,3 with tick every 2 clks.
  - done pulses once 8 clks after RUN entry; count stays 3 in DONE.
- Down wrap: limit=2, div=0, dir=1, wrap=1.
  - count sequence 2,1,0,2,1,0,... with tick every clk; done never asserted.
- Pause: limit=10, div=3.
  - Assert pause for 7 clks mid-period: count and prescaler frozen, paused=1, tick=0.
  - After release, the next tick arrives after exactly the remaining prescaler cycles.
- Priority: start and stop high in same cycle during RUN.
  - Next cycle IDLE, count=0.
  - Then start alone during RUN with new limit=5: count reloads to 0 and the new limit is used.
- Edge values:
  - limit=0, one-shot: done after div+1 clks, count stays 0.
  - limit=255, div=0, up wrap: count 255 then 0, no overflow glitch.
- Async reset: assert rst between clk edges while in RUN with count=5.
  - count=0 and running=0 before the next clk edge; no done pulse after release.
